time_core: RTL and testbench

Running timekeeper for the BCD clock/calendar datapath. It divides the 1 kHz system clock to a 1 Hz tick and advances packed-BCD seconds, minutes, hours and day. Its `CUR_*` outputs feed the manual-set stage's `PREV_*` inputs. It takes that stage's `*_SET` outputs back whenever set mode (`SW1`) is active, so edited time resumes counting when set mode exits.

---
 rtl/time_core_if.sv | 26 ++
 rtl/time_core.sv | 122 ++++++++++++
 tb/tb_time_core.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/time_core_if.sv
// Bus between the manual-set stage and the running timekeeper: set-mode
// control and BCD edit values in, current time and timing pulses out.
interface time_core_if;
    logic       SW1;
    logic [7:0] SEC_SET;
    logic [7:0] MIN_SET;
    logic [7:0] HOUR_SET;
    logic [7:0] DAY_SET;
    logic [7:0] CUR_SEC;
    logic [7:0] CUR_MIN;
    logic [7:0] CUR_HOUR;
    logic [7:0] CUR_DAY;
    logic       TICK_1HZ;
    logic       DAY_CARRY;
    logic       BLINK;

    modport master (
        output SW1, SEC_SET, MIN_SET, HOUR_SET, DAY_SET,
        input  CUR_SEC, CUR_MIN, CUR_HOUR, CUR_DAY, TICK_1HZ, DAY_CARRY, BLINK
    );

    modport slave (
        input  SW1, SEC_SET, MIN_SET, HOUR_SET, DAY_SET,
        output CUR_SEC, CUR_MIN, CUR_HOUR, CUR_DAY, TICK_1HZ, DAY_CARRY, BLINK
    );
endinterface

// File: rtl/time_core.sv
// Packed-BCD seconds/minutes/hours/day timekeeper with a 1 Hz prescaler.
// Optional macro TIME_CORE_FASTSIM_EN forces a terminal count of 9.
module time_core #(
    parameter int PRESC_MAX = 999
) (
    input  logic         CLK1K,
    input  logic         RST,
    time_core_if.slave   bus
);

`ifdef TIME_CORE_FASTSIM_EN
    localparam int TERM = 9;
`else
    localparam int TERM = PRESC_MAX;
`endif
    localparam logic [9:0] TERM_C = 10'(TERM);
    localparam logic [9:0] HALF_C = 10'(TERM / 2);

    logic [9:0] presc_r;
    logic       sw1_d_r;
    logic [7:0] sec_r;
    logic [7:0] min_r;
    logic [7:0] hour_r;
    logic [7:0] day_r;
    logic       tick_r;
    logic       day_carry_r;
    logic       blink_r;

    logic       load_s;
    logic [7:0] sec_nxt_s;
    logic [7:0] min_nxt_s;
    logic [7:0] hour_nxt_s;
    logic [7:0] day_nxt_s;
    logic       sec_c_s;
    logic       min_c_s;
    logic       hour_c_s;
    logic       day_c_s;
    logic       min_adv_s;
    logic       hour_adv_s;
    logic       day_adv_s;

    // One BCD field step: {carry, next}. Non-BCD values follow the same rule.
    function automatic logic [8:0] bcd_step(input logic [7:0] val,
                                            input logic [7:0] max_val,
                                            input logic [7:0] wrap_val);
        logic [8:0] res;
        if (val == max_val) begin
            res = {1'b1, wrap_val};
        end else if (val[3:0] == 4'd9) begin
            res = {1'b0, val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {1'b0, val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    // Load window stretches one cycle past SW1 to catch the final edit.
    always_comb begin
        load_s = bus.SW1 | sw1_d_r;
    end

    // Next value of every field with the carries rippling in one advance.
    always_comb begin
        {sec_c_s,  sec_nxt_s}  = bcd_step(sec_r,  8'h59, 8'h00);
        {min_c_s,  min_nxt_s}  = bcd_step(min_r,  8'h59, 8'h00);
        {hour_c_s, hour_nxt_s} = bcd_step(hour_r, 8'h23, 8'h00);
        {day_c_s,  day_nxt_s}  = bcd_step(day_r,  8'h31, 8'h01);
        min_adv_s  = sec_c_s;
        hour_adv_s = sec_c_s & min_c_s;
        day_adv_s  = hour_adv_s & hour_c_s;
    end

    // Prescaler, time registers and registered pulses; reset beats load beats count.
    always_ff @(posedge CLK1K) begin
        if (RST) begin
            presc_r     <= 10'd0;
            sw1_d_r     <= 1'b0;
            sec_r       <= 8'h00;
            min_r       <= 8'h00;
            hour_r      <= 8'h00;
            day_r       <= 8'h01;
            tick_r      <= 1'b0;
            day_carry_r <= 1'b0;
            blink_r     <= 1'b0;
        end else begin
            sw1_d_r <= bus.SW1;
            if (load_s) begin
                presc_r     <= 10'd0;
                sec_r       <= bus.SEC_SET;
                min_r       <= bus.MIN_SET;
                hour_r      <= bus.HOUR_SET;
                day_r       <= bus.DAY_SET;
                tick_r      <= 1'b0;
                day_carry_r <= 1'b0;
                blink_r     <= 1'b0;
            end else if (presc_r == TERM_C) begin
                presc_r     <= 10'd0;
                sec_r       <= sec_nxt_s;
                min_r       <= min_adv_s  ? min_nxt_s  : min_r;
                hour_r      <= hour_adv_s ? hour_nxt_s : hour_r;
                day_r       <= day_adv_s  ? day_nxt_s  : day_r;
                tick_r      <= 1'b1;
                day_carry_r <= day_adv_s & day_c_s;
                blink_r     <= ~blink_r;
            end else begin
                presc_r     <= presc_r + 10'd1;
                tick_r      <= 1'b0;
                day_carry_r <= 1'b0;
                blink_r     <= (presc_r == HALF_C) ? ~blink_r : blink_r;
            end
        end
    end

    assign bus.CUR_SEC   = sec_r;
    assign bus.CUR_MIN   = min_r;
    assign bus.CUR_HOUR  = hour_r;
    assign bus.CUR_DAY   = day_r;
    assign bus.TICK_1HZ  = tick_r;
    assign bus.DAY_CARRY = day_carry_r;
    assign bus.BLINK     = blink_r;

endmodule

// File: tb/tb_time_core.sv
// Directed, table-driven bench for time_core with PRESC_MAX = 999.
module tb_time_core;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    time_core_if bus ();

    time_core #(.PRESC_MAX(999)) dut (
        .CLK1K (clk),
        .RST   (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s, m, h, d;
        logic [7:0] es, em, eh, ed;
        logic       edc;
    } vec_t;

    vec_t vt [10];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cur_time();
        return {bus.CUR_HOUR, bus.CUR_MIN, bus.CUR_SEC, bus.CUR_DAY};
    endfunction

    task automatic set_vals(input logic [7:0] s, input logic [7:0] m,
                            input logic [7:0] h, input logic [7:0] d);
        bus.SEC_SET  = s;
        bus.MIN_SET  = m;
        bus.HOUR_SET = h;
        bus.DAY_SET  = d;
    endtask

    initial begin
        bit bad;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.SW1 = 1'b0;
        set_vals(8'h00, 8'h00, 8'h00, 8'h01);

        vt[0] = '{8'h09, 8'h00, 8'h00, 8'h01, 8'h10, 8'h00, 8'h00, 8'h01, 1'b0};
        vt[1] = '{8'h59, 8'h59, 8'h23, 8'h31, 8'h00, 8'h00, 8'h00, 8'h01, 1'b1};
        vt[2] = '{8'h56, 8'h34, 8'h12, 8'h15, 8'h57, 8'h34, 8'h12, 8'h15, 1'b0};
        vt[3] = '{8'h59, 8'h59, 8'h00, 8'h05, 8'h00, 8'h00, 8'h01, 8'h05, 1'b0};
        vt[4] = '{8'h59, 8'h59, 8'h09, 8'h09, 8'h00, 8'h00, 8'h10, 8'h09, 1'b0};
        vt[5] = '{8'h59, 8'h59, 8'h19, 8'h29, 8'h00, 8'h00, 8'h20, 8'h29, 1'b0};
        vt[6] = '{8'h59, 8'h59, 8'h23, 8'h09, 8'h00, 8'h00, 8'h00, 8'h10, 1'b0};
        vt[7] = '{8'h59, 8'h59, 8'h23, 8'h30, 8'h00, 8'h00, 8'h00, 8'h31, 1'b0};
        vt[8] = '{8'h4A, 8'h00, 8'h00, 8'h01, 8'h4B, 8'h00, 8'h00, 8'h01, 1'b0};
        vt[9] = '{8'h59, 8'h09, 8'h00, 8'h01, 8'h00, 8'h10, 8'h00, 8'h01, 1'b0};

        // Reset, then the first tick and the BLINK phases of the first second.
        step(2);
        chk("reset_time", cur_time(), 32'h00_00_00_01);
        chk("reset_pulses", {29'd0, bus.TICK_1HZ, bus.DAY_CARRY, bus.BLINK}, 32'd0);
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            step(1);
            if (k < 1000 && (bus.TICK_1HZ !== 1'b0 || cur_time() !== 32'h00_00_00_01)) bad = 1'b1;
            if (k == 499) chk("blink_before_half", {31'd0, bus.BLINK}, 32'd0);
            if (k == 500) chk("blink_at_half", {31'd0, bus.BLINK}, 32'd1);
        end
        chk("first_sec_hold", {31'd0, bad}, 32'd0);
        chk("first_tick_time", cur_time(), 32'h00_00_01_01);
        chk("first_tick_pulse", {30'd0, bus.TICK_1HZ, bus.BLINK}, 32'd2);
        step(1);
        chk("first_tick_width", {31'd0, bus.TICK_1HZ}, 32'd0);

        // Table of load-then-advance vectors.
        for (int i = 0; i < 10; i++) begin
            set_vals(vt[i].s, vt[i].m, vt[i].h, vt[i].d);
            bus.SW1 = 1'b1;
            step(2);
            bus.SW1 = 1'b0;
            step(1);
            chk($sformatf("v%0d_load", i), cur_time(), {vt[i].h, vt[i].m, vt[i].s, vt[i].d});
            step(999);
            chk($sformatf("v%0d_hold", i), {cur_time()}, {vt[i].h, vt[i].m, vt[i].s, vt[i].d});
            chk($sformatf("v%0d_no_early_tick", i), {31'd0, bus.TICK_1HZ}, 32'd0);
            step(1);
            chk($sformatf("v%0d_adv", i), cur_time(), {vt[i].eh, vt[i].em, vt[i].es, vt[i].ed});
            chk($sformatf("v%0d_pulses", i), {30'd0, bus.TICK_1HZ, bus.DAY_CARRY}, {30'd0, 1'b1, vt[i].edc});
            step(1);
            chk($sformatf("v%0d_pulse_width", i), {30'd0, bus.TICK_1HZ, bus.DAY_CARRY}, 32'd0);
        end

        // Set-mode exit: edit made in the cycle after SW1 falls is captured.
        set_vals(8'h00, 8'h14, 8'h00, 8'h01);
        bus.SW1 = 1'b1;
        step(2);
        bus.SW1 = 1'b0;
        bus.MIN_SET = 8'h15;
        step(1);
        chk("exit_lag_min", {24'd0, bus.CUR_MIN}, 32'h15);
        bus.MIN_SET = 8'h77;
        step(999);
        chk("exit_lag_hold", cur_time(), 32'h00_15_00_01);
        chk("exit_lag_no_tick", {31'd0, bus.TICK_1HZ}, 32'd0);
        step(1);
        chk("exit_lag_adv", cur_time(), 32'h00_15_01_01);
        chk("exit_lag_tick", {31'd0, bus.TICK_1HZ}, 32'd1);

        // Load raised exactly on the terminal count wins over the advance.
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(999);
        set_vals(8'h30, 8'h00, 8'h00, 8'h01);
        bus.SW1 = 1'b1;
        step(1);
        chk("load_vs_tc_time", cur_time(), 32'h00_00_30_01);
        chk("load_vs_tc_tick", {31'd0, bus.TICK_1HZ}, 32'd0);
        bus.SW1 = 1'b0;
        step(1);
        step(999);
        chk("load_vs_tc_restart_hold", {23'd0, bus.TICK_1HZ, bus.CUR_SEC}, 32'h030);
        step(1);
        chk("load_vs_tc_restart_adv", {23'd0, bus.TICK_1HZ, bus.CUR_SEC}, 32'h131);

        // Reset mid-count at PRESC 700, concurrent with SW1, then BLINK phases.
        set_vals(8'h56, 8'h34, 8'h12, 8'h01);
        bus.SW1 = 1'b1;
        step(2);
        bus.SW1 = 1'b0;
        step(1);
        step(700);
        chk("mid_pre_reset", {cur_time()}, 32'h12_34_56_01);
        chk("mid_pre_reset_blink", {31'd0, bus.BLINK}, 32'd1);
        rst = 1'b1;
        bus.SW1 = 1'b1;
        set_vals(8'h44, 8'h44, 8'h44, 8'h44);
        step(1);
        chk("mid_reset_time", cur_time(), 32'h00_00_00_01);
        chk("mid_reset_blink", {30'd0, bus.BLINK, bus.TICK_1HZ}, 32'd0);
        rst = 1'b0;
        bus.SW1 = 1'b0;
        set_vals(8'h00, 8'h00, 8'h00, 8'h01);
        step(499);
        chk("mid_blink_low", {31'd0, bus.BLINK}, 32'd0);
        step(1);
        chk("mid_blink_rise", {31'd0, bus.BLINK}, 32'd1);
        step(499);
        chk("mid_blink_high_hold", {23'd0, bus.BLINK, bus.CUR_SEC}, 32'h100);
        step(1);
        chk("mid_blink_fall_adv", {22'd0, bus.TICK_1HZ, bus.BLINK, bus.CUR_SEC}, 32'h201);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
